// File: rtl/spi_master_multi_periph.sv
// Bus-mapped SPI master with configurable frame width, SPI mode, SCK divider,
// bit order and slave select; reports completion and overrun through STAT.
module spi_master_multi_periph #(
  parameter int DATA_W  = 8,
  parameter int N_SS    = 2,
  parameter int DEF_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     d_in,
  input  logic            cs,
  input  logic [3:0]      addr,
  input  logic            rd,
  input  logic            wr,
  output logic [15:0]     d_out,
  input  logic            miso,
  output logic            mosi,
  output logic            sck,
  output logic [N_SS-1:0] ss
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_CTRL = 4'h2;
  localparam logic [3:0] A_RX   = 4'h4;
  localparam logic [3:0] A_CFG  = 4'h6;
  localparam logic [3:0] A_STAT = 4'h8;

  localparam logic [5:0] LAST_EDGE = 6'(2 * DATA_W - 1);

  typedef struct packed {
    logic [7:0] div;
    logic [3:0] ss_sel;
    logic       lsb_first;
    logic       cpha;
    logic       cpol;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: 8'(DEF_DIV), ss_sel: 4'd0, lsb_first: 1'b0,
                               cpha: 1'b0, cpol: 1'b0};

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  cfg_t              cfg_q, cfg_d, wcfg_q, wcfg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [5:0]        edge_q, edge_d;
  logic              sck_q, sck_d;
  logic              done_q, done_d, busy_q, busy_d, ovr_q, ovr_d;

  logic              wr_en, rd_en, tick, leading, active;
  logic              do_sample, do_shift;
  logic [DATA_W-1:0] rx_shift, tx_shift;

  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign tick    = (cnt_q == 8'd0);
  assign leading = ~edge_q[0];
  assign active  = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

  // CPHA=1 presents its first bit during SETUP, so the first leading edge must not shift.
  assign do_sample = tick && (state_q == ST_XFER) && (wcfg_q.cpha ? ~leading : leading);
  assign do_shift  = tick && (state_q == ST_XFER) &&
                     (wcfg_q.cpha ? (leading && edge_q != 6'd0) : ~leading);

  always_comb begin
    rx_shift = wcfg_q.lsb_first ? (rx_sh_q >> 1) : (rx_sh_q << 1);
    if (wcfg_q.lsb_first) rx_shift[DATA_W-1] = miso;
    else                  rx_shift[0]        = miso;
    tx_shift = wcfg_q.lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a latch behind.
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    cfg_d   = cfg_q;
    wcfg_d  = wcfg_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sck_d   = sck_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;

    if (wr_en && addr == A_TX) tx_d = d_in[DATA_W-1:0];
    if (wr_en && addr == A_CFG)
      cfg_d = '{div: d_in[15:8], ss_sel: d_in[7:4], lsb_first: d_in[2],
                cpha: d_in[1], cpol: d_in[0]};
    if (rd_en && addr == A_RX) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (state_q != ST_IDLE && state_q != ST_DONE)
      cnt_d = tick ? wcfg_q.div : cnt_q - 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (wr_en && addr == A_CTRL && d_in[0]) begin
          state_d = ST_SETUP;
          tx_sh_d = tx_q;
          wcfg_d  = cfg_q;
          sck_d   = cfg_q.cpol;
          cnt_d   = cfg_q.div;
          edge_d  = 6'd0;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + 6'd1;
          if (edge_q == LAST_EDGE) state_d = ST_HOLD;
        end
        if (do_sample) rx_sh_d = rx_shift;
        if (do_shift)  tx_sh_d = tx_shift;
      end
      ST_HOLD: if (tick) state_d = ST_DONE;
      ST_DONE: begin
        // Completion overrides a same-cycle RX read.
        rx_d    = rx_sh_q;
        done_d  = 1'b1;
        ovr_d   = ovr_q | done_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      cfg_q   <= CFG_RST;
      wcfg_q  <= CFG_RST;
      cnt_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      cfg_q   <= cfg_d;
      wcfg_q  <= wcfg_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sck  = (state_q == ST_IDLE) ? cfg_q.cpol : sck_q;
  assign mosi = active & (wcfg_q.lsb_first ? tx_sh_q[0] : tx_sh_q[DATA_W-1]);

  always_comb begin
    ss = '1;
    for (int i = 0; i < N_SS; i++)
      if (active && wcfg_q.ss_sel == 4'(i)) ss[i] = 1'b0;
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        A_TX:    d_out[DATA_W-1:0] = tx_q;
        A_RX:    d_out[DATA_W-1:0] = rx_q;
        A_CFG:   d_out = {cfg_q.div, cfg_q.ss_sel, 1'b0, cfg_q.lsb_first, cfg_q.cpha, cfg_q.cpol};
        A_STAT:  d_out = {13'd0, ovr_q, busy_q, done_q};
        default: d_out = '0;
      endcase
    end
  end

endmodule
